// File: rtl/ambilight_pkg.sv
// Shared types and default timing for the ambilight WS2812 transmitter.
// The LED count follows the averaging stage: top edge plus both side edges.
package ambilight_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_SEND  = 3'd3,
        ST_LATCH = 3'd4
    } tx_state_e;

    localparam int NUM_H        = 8;
    localparam int NUM_V        = 6;
    localparam int DEF_NUM_LEDS = NUM_H + 2 * NUM_V;
    localparam int DEF_T0H      = 40;
    localparam int DEF_T1H      = 80;
    localparam int DEF_TBIT     = 125;
    localparam int DEF_TLATCH   = 5000;

    // WS2812 expects green first, so the {R,G,B} buffer word is reordered to {G,R,B}
    function automatic logic [23:0] grb_order(input logic [23:0] rgb);
        return {rgb[15:8], rgb[23:16], rgb[7:0]};
    endfunction

endpackage

// File: rtl/ambilight_led_tx_bit_timer.sv
// Single WS2812 bit waveform: high for T0H/T1H cycles, low for the rest of TBIT.
// A load on the cycle bit_done is high chains bits with no gap; otherwise it goes idle low.
module ws2812_bit_timer #(
    parameter int T0H  = 40,
    parameter int T1H  = 80,
    parameter int TBIT = 125
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic bit_val,
    output logic dout,
    output logic bit_done
);

    localparam int CW = $clog2(TBIT);

    logic [CW-1:0] cnt_r;
    logic [CW-1:0] hi_len_r;
    logic          active_r;
    logic          dout_r;

    // Bit-period counter and registered line level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r    <= '0;
            hi_len_r <= '0;
            active_r <= 1'b0;
            dout_r   <= 1'b0;
        end else if (load) begin
            cnt_r    <= '0;
            hi_len_r <= bit_val ? CW'(T1H) : CW'(T0H);
            active_r <= 1'b1;
            dout_r   <= 1'b1;
        end else if (active_r) begin
            if (cnt_r == CW'(TBIT - 1)) begin
                cnt_r    <= '0;
                active_r <= 1'b0;
                dout_r   <= 1'b0;
            end else begin
                cnt_r  <= cnt_r + CW'(1);
                dout_r <= ((cnt_r + CW'(1)) < hi_len_r);
            end
        end else begin
            dout_r <= 1'b0;
        end
    end

    assign dout     = dout_r;
    assign bit_done = active_r && (cnt_r == CW'(TBIT - 1));

endmodule

// File: rtl/ambilight_led_tx.sv
// Streams one frame of NUM_LEDS colour words from the averaging buffer onto a WS2812 line.
// The next word is prefetched during bit 0 so LEDs follow each other without a gap.
module ambilight_led_tx
    import ambilight_pkg::*;
#(
    parameter int NUM_LEDS = DEF_NUM_LEDS,
    parameter int T0H      = DEF_T0H,
    parameter int T1H      = DEF_T1H,
    parameter int TBIT     = DEF_TBIT,
    parameter int TLATCH   = DEF_TLATCH
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [7:0]  led_addr,
    output logic        rd_en,
    input  logic [23:0] led_rgb,
    output logic        dout,
    output logic        busy,
    output logic        done
);

    localparam int          LW       = $clog2(TLATCH);
    localparam logic [7:0]  LAST_LED = 8'(NUM_LEDS - 1);

    tx_state_e     state_r;
    tx_state_e     state_nxt_s;
    logic [23:0]   word_s;
    logic [23:0]   shift_r;
    logic [23:0]   next_word_r;
    logic [4:0]    bit_idx_r;
    logic [LW-1:0] latch_cnt_r;
    logic [7:0]    led_addr_r;
    logic          rd_en_r;
    logic          rd_d_r;
    logic          busy_r;
    logic          done_r;
    logic          pf_issued_r;
    logic          tmr_load_s;
    logic          tmr_bit_s;
    logic          bit_done_s;
    logic          last_bit_s;

    assign word_s     = grb_order(led_rgb);
    assign last_bit_s = bit_done_s && (bit_idx_r == 5'd0) && !pf_issued_r;

    ws2812_bit_timer #(
        .T0H  (T0H),
        .T1H  (T1H),
        .TBIT (TBIT)
    ) u_bit_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load_s),
        .bit_val  (tmr_bit_s),
        .dout     (dout),
        .bit_done (bit_done_s)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state and bit-timer load strobe
    always_comb begin
        state_nxt_s = state_r;
        tmr_load_s  = 1'b0;
        tmr_bit_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_FETCH;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FETCH: state_nxt_s = ST_LOAD;
            ST_LOAD: begin
                state_nxt_s = ST_SEND;
                tmr_load_s  = 1'b1;
                tmr_bit_s   = word_s[23];
            end
            ST_SEND: begin
                if (last_bit_s) begin
                    state_nxt_s = ST_LATCH;
                end else if (bit_done_s) begin
                    tmr_load_s = 1'b1;
                    tmr_bit_s  = (bit_idx_r != 5'd0) ? shift_r[22] : next_word_r[23];
                end else begin
                    state_nxt_s = ST_SEND;
                end
            end
            ST_LATCH: begin
                if (latch_cnt_r == LW'(TLATCH - 1)) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_LATCH;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Datapath: word fetch/prefetch, shift register, latch timing and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_addr_r  <= 8'd0;
            rd_en_r     <= 1'b0;
            rd_d_r      <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            shift_r     <= 24'd0;
            next_word_r <= 24'd0;
            bit_idx_r   <= 5'd0;
            latch_cnt_r <= '0;
            pf_issued_r <= 1'b0;
        end else begin
            rd_en_r <= 1'b0;
            done_r  <= 1'b0;
            rd_d_r  <= rd_en_r;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        led_addr_r  <= 8'd0;
                        rd_en_r     <= 1'b1;
                        busy_r      <= 1'b1;
                        pf_issued_r <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    pf_issued_r <= 1'b0;
                end
                ST_LOAD: begin
                    shift_r   <= word_s;
                    bit_idx_r <= 5'd23;
                end
                ST_SEND: begin
                    if (rd_d_r) begin
                        next_word_r <= word_s;
                    end
                    if (bit_done_s) begin
                        if (bit_idx_r != 5'd0) begin
                            shift_r   <= {shift_r[22:0], 1'b0};
                            bit_idx_r <= bit_idx_r - 5'd1;
                        end else if (pf_issued_r) begin
                            shift_r     <= next_word_r;
                            bit_idx_r   <= 5'd23;
                            pf_issued_r <= 1'b0;
                        end else begin
                            latch_cnt_r <= '0;
                        end
                    end else if ((bit_idx_r == 5'd0) && !pf_issued_r && (led_addr_r != LAST_LED)) begin
                        rd_en_r     <= 1'b1;
                        led_addr_r  <= led_addr_r + 8'd1;
                        pf_issued_r <= 1'b1;
                    end
                end
                ST_LATCH: begin
                    latch_cnt_r <= latch_cnt_r + LW'(1);
                    if (latch_cnt_r == LW'(TLATCH - 2)) begin
                        done_r <= 1'b1;
                    end
                    if (latch_cnt_r == LW'(TLATCH - 1)) begin
                        busy_r <= 1'b0;
                    end
                end
                default: begin
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign led_addr = led_addr_r;
    assign rd_en    = rd_en_r;
    assign busy     = busy_r;
    assign done     = done_r;

endmodule

// File: tb/tb_ambilight_led_tx.sv
// Directed bench: a 2-LED and a 1-LED transmitter, with the serial line decoded by pulse width.
module tb_ambilight_led_tx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start2 = 1'b0, start1 = 1'b0;
    logic [7:0]  led_addr2, led_addr1;
    logic        rd_en2, rd_en1;
    logic [23:0] led_rgb2 = 24'd0, led_rgb1 = 24'd0;
    logic [23:0] rgb2_val = 24'd0, rgb1_val = 24'd0;
    logic        dout2, dout1, busy2, busy1, done2, done1;
    logic        sel = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int rises[$];
    int highs[$];
    int hi_start = 0;
    logic prev_dout = 1'b0;
    int rd_cnt = 0, done_cnt = 0, done_cyc = 0;
    int max_addr2 = 0, max_addr1 = 0;
    int b_rise, b_high, b_rd, b_done, st_cyc;

    always #5 clk = ~clk;

    ambilight_led_tx #(.NUM_LEDS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .led_addr(led_addr2), .rd_en(rd_en2),
        .led_rgb(led_rgb2), .dout(dout2), .busy(busy2), .done(done2));

    ambilight_led_tx #(.NUM_LEDS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .led_addr(led_addr1), .rd_en(rd_en1),
        .led_rgb(led_rgb1), .dout(dout1), .busy(busy1), .done(done1));

    // Buffer model: data valid the cycle after rd_en, filler otherwise
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        led_rgb2 <= rd_en2 ? rgb2_val : 24'h5A5A5A;
        led_rgb1 <= rd_en1 ? rgb1_val : 24'hA5A5A5;
    end

    wire m_dout = sel ? dout1 : dout2;
    wire m_rd   = sel ? rd_en1 : rd_en2;
    wire m_done = sel ? done1 : done2;

    // Line decoder and event counters
    always @(negedge clk) begin
        if (m_dout && !prev_dout) begin
            rises.push_back(cyc);
            hi_start = cyc;
        end
        if (!m_dout && prev_dout) highs.push_back(cyc - hi_start);
        prev_dout = m_dout;
        if (m_rd) rd_cnt++;
        if (m_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (int'(led_addr2) > max_addr2) max_addr2 = int'(led_addr2);
        if (int'(led_addr1) > max_addr1) max_addr1 = int'(led_addr1);
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic snapshot();
        b_rise = rises.size();
        b_high = highs.size();
        b_rd   = rd_cnt;
        b_done = done_cnt;
    endtask

    task automatic pulse_start(input bit which);
        @(negedge clk);
        if (which) start1 = 1'b1; else start2 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        start2 = 1'b0;
        st_cyc = cyc;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done_cnt == b_done && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt == b_done) check_val({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_bits(input int nb, input string tag);
        int n = 0;
        while (rises.size() - b_rise < nb && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (rises.size() - b_rise < nb) check_val({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    function automatic logic [7:0] get_byte(input int n);
        logic [7:0] b = 8'd0;
        for (int i = 0; i < 8; i++) begin
            if (b_high + 8 * n + i < highs.size())
                b = {b[6:0], (highs[b_high + 8 * n + i] == 80)};
        end
        return b;
    endfunction

    function automatic int bad_periods(input int nbits);
        int bad = 0;
        for (int i = 0; i < nbits - 1; i++) begin
            if (b_rise + i + 1 >= rises.size()) bad++;
            else if (rises[b_rise + i + 1] - rises[b_rise + i] != 125) bad++;
        end
        return bad;
    endfunction

    initial begin
        logic [7:0] exp_bytes [6];
        int bad;

        // Reset state
        repeat (3) @(negedge clk);
        check_val("rst_dout", {31'd0, dout2}, 32'd0);
        check_val("rst_busy", {31'd0, busy2}, 32'd0);
        check_val("rst_done", {31'd0, done2}, 32'd0);
        check_val("rst_rd_en", {31'd0, rd_en2}, 32'd0);
        check_val("rst_addr", {24'd0, led_addr2}, 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Constant FF0080 on two LEDs: G,R,B = 00,FF,80 twice
        rgb2_val = 24'hFF0080;
        snapshot();
        pulse_start(1'b0);
        wait_done("t031");
        check_val("t031_first_rise", rises[b_rise], st_cyc + 2);
        check_val("t031_nbits", rises.size() - b_rise, 32'd48);
        exp_bytes = '{8'h00, 8'hFF, 8'h80, 8'h00, 8'hFF, 8'h80};
        for (int i = 0; i < 6; i++) check_val($sformatf("t031_byte%0d", i), {24'd0, get_byte(i)}, {24'd0, exp_bytes[i]});
        check_val("t031_frame_len", done_cyc - rises[b_rise] + 1, 32'd11000);
        check_val("t031_bad_periods", bad_periods(48), 32'd0);
        check_val("t034_gap", rises[b_rise + 24] - rises[b_rise + 23], 32'd125);
        check_val("t031_rd_cnt", rd_cnt - b_rd, 32'd2);
        check_val("t031_done_cnt", done_cnt - b_done, 32'd1);
        repeat (5) @(negedge clk);
        check_val("t031_busy_end", {31'd0, busy2}, 32'd0);

        // R MSB only, with start pulses during SEND and LATCH
        rgb2_val = 24'h800000;
        snapshot();
        pulse_start(1'b0);
        repeat (1000) @(negedge clk);
        pulse_start(1'b0);
        wait_bits(48, "t033");
        repeat (300) @(negedge clk);
        check_val("t033_in_latch_busy", {31'd0, busy2}, 32'd1);
        pulse_start(1'b0);
        wait_done("t032");
        repeat (20) @(negedge clk);
        check_val("t032_bit8_led0", highs[b_high + 8], 32'd80);
        check_val("t032_bit8_led1", highs[b_high + 32], 32'd80);
        bad = 0;
        for (int i = 0; i < 48; i++) begin
            if (b_high + i >= highs.size()) bad++;
            else if (highs[b_high + i] != (((i % 24) == 8) ? 80 : 40)) bad++;
        end
        check_val("t032_bad_highs", bad, 32'd0);
        check_val("t032_bad_periods", bad_periods(48), 32'd0);
        check_val("t033_done_cnt", done_cnt - b_done, 32'd1);
        check_val("t033_rd_cnt", rd_cnt - b_rd, 32'd2);
        check_val("t033_busy_after", {31'd0, busy2}, 32'd0);
        check_val("t033_nbits", rises.size() - b_rise, 32'd48);

        // Reset in the middle of LED 1, then a fresh frame
        rgb2_val = 24'h123456;
        snapshot();
        pulse_start(1'b0);
        wait_bits(30, "t035a");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("t035_dout_rst", {31'd0, dout2}, 32'd0);
        check_val("t035_busy_rst", {31'd0, busy2}, 32'd0);
        check_val("t035_addr_rst", {24'd0, led_addr2}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_val("t035_no_done", done_cnt - b_done, 32'd0);
        snapshot();
        pulse_start(1'b0);
        wait_done("t035b");
        check_val("t035_first_rise", rises[b_rise], st_cyc + 2);
        exp_bytes = '{8'h34, 8'h12, 8'h56, 8'h34, 8'h12, 8'h56};
        for (int i = 0; i < 6; i++) check_val($sformatf("t035_byte%0d", i), {24'd0, get_byte(i)}, {24'd0, exp_bytes[i]});
        check_val("t035_frame_len", done_cyc - rises[b_rise] + 1, 32'd11000);
        check_val("t035_rd_cnt", rd_cnt - b_rd, 32'd2);
        check_val("t024_max_addr2", max_addr2, 32'd1);

        // Single LED, all-zero colour
        sel = 1'b1;
        rgb1_val = 24'h000000;
        repeat (3) @(negedge clk);
        snapshot();
        pulse_start(1'b1);
        wait_done("t036");
        check_val("t036_nbits", rises.size() - b_rise, 32'd24);
        bad = 0;
        for (int i = 0; i < 24; i++) begin
            if (b_high + i >= highs.size()) bad++;
            else if (highs[b_high + i] != 40) bad++;
        end
        check_val("t036_bad_highs", bad, 32'd0);
        check_val("t036_bad_periods", bad_periods(24), 32'd0);
        check_val("t036_latch_len", done_cyc - rises[rises.size() - 1] - 125 + 1, 32'd5000);
        check_val("t036_frame_len", done_cyc - rises[b_rise] + 1, 32'd8000);
        check_val("t036_rd_cnt", rd_cnt - b_rd, 32'd1);
        check_val("t036_max_addr1", max_addr1, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ambilight_led_tx.md
AMBILIGHT_LED_TX -- requirements
Module: ambilight_led_tx

Interface
REQ-001 Parameter NUM_LEDS, default 20, SHALL be the number of LEDs per frame (num_h + 2*num_v of the averaging stage).
REQ-002 Parameter T0H, default 40, SHALL be the high time of a '0' bit, in clk cycles.
REQ-003 Parameter T1H, default 80, SHALL be the high time of a '1' bit, in clk cycles.
REQ-004 Parameter TBIT, default 125, SHALL be the full bit period, in clk cycles (1.25 us at 100 MHz).
REQ-005 Parameter TLATCH, default 5000, SHALL be the low latch/reset time after the last bit, in clk cycles.
REQ-006 Port clk, input, 1: the single clock; all logic SHALL be on its rising edge.
REQ-007 Port rst_n, input, 1: asynchronous active-low reset.
REQ-008 Port start, input, 1: one-cycle request to send one frame.
REQ-009 Port led_addr, output, 8: LED index being fetched from the averaging buffer.
REQ-010 Port rd_en, output, 1: one-cycle read strobe for led_addr.
REQ-011 Port led_rgb, input, 24: {R,G,B} word, valid exactly one cycle after rd_en.
REQ-012 Port dout, output, 1: WS2812 serial data line.
REQ-013 Port busy, output, 1: high from start acceptance until the latch period ends.
REQ-014 Port done, output, 1: one-cycle pulse in the last latch cycle.

Function
REQ-015 The FSM SHALL have the states IDLE, FETCH, LOAD, SEND, and LATCH.
REQ-016 In IDLE with start=1, the next state SHALL be FETCH with led_addr=0; start in any other state SHALL be ignored.
REQ-017 FETCH SHALL assert rd_en for one cycle; LOAD SHALL capture led_rgb into a 24-bit shift register reordered as {G,R,B}.
REQ-018 SEND SHALL transmit the shift register MSB first: dout=1 for T0H or T1H cycles, then 0 for the remainder of TBIT.
REQ-019 The first dout rising edge SHALL occur in the third cycle after the start sample edge.
REQ-020 Bit 23 of each word SHALL be the G MSB; bit 0 SHALL be the B LSB.
REQ-021 While bit 0 of LED n (n < NUM_LEDS-1) is transmitting, the block SHALL issue rd_en with led_addr=n+1 and capture the result, so consecutive LEDs have no gap (exactly TBIT per bit).
REQ-022 After bit 0 of LED NUM_LEDS-1, the state SHALL be LATCH with dout=0 for TLATCH cycles; done SHALL pulse in the final cycle; the next state SHALL be IDLE.
REQ-023 A full frame SHALL be NUM_LEDS*24*TBIT + TLATCH cycles of dout activity.
REQ-024 led_addr SHALL never exceed NUM_LEDS-1, and rd_en SHALL fire exactly NUM_LEDS times per frame.
REQ-025 NUM_LEDS=1 SHALL work: no prefetch, direct transition to LATCH.
REQ-026 The bit and latch counters SHALL be sized by $clog2 of their maximum parameter; the bit-index counter SHALL be 5 bits and wrap from 0 to 23 on word reload.

Reset
REQ-027 rst_n=0 SHALL asynchronously force the state to IDLE, dout=0, rd_en=0, busy=0, done=0, led_addr=0, and all counters and the shift register to 0.
REQ-028 Reset mid-frame SHALL abort the frame without a done pulse; the next start after release SHALL begin a fresh frame at LED 0.

Structure
REQ-029 Package ambilight_pkg SHALL hold the state enum, the default timing constants, and the NUM_LEDS default derived from num_h/num_v.
REQ-030 One sub-module, ws2812_bit_timer (bit value in, load strobe, dout and bit_done out), SHALL generate the per-bit waveform.

Verification
REQ-031 NUM_LEDS=2, led_rgb constant 24'hFF0080: the decoded stream SHALL be 00,FF,80 twice, and done SHALL come 11000 cycles after the first dout rise.
REQ-032 Bit 24'h800000 (R MSB): the high pulse in bit 8 SHALL be 80 cycles; all other bits SHALL be 40 cycles high, 125-cycle period.
REQ-033 A start pulse during SEND and again during LATCH SHALL be ignored: there SHALL be a single done, and rd_en SHALL count exactly NUM_LEDS.
REQ-034 The gap check at the LED 0→1 boundary SHALL show the rising edges of bit 0 of LED 0 and bit 23 of LED 1 exactly 125 cycles apart.
REQ-035 rst_n low for 3 cycles mid-LED-1: dout=0 and busy=0 immediately with no done; a following start SHALL produce a complete frame.
REQ-036 NUM_LEDS=1, led_rgb=24'h000000: there SHALL be 24 bits of 40-cycle highs, then done after 5000 low cycles.
